countdown_timer_ctrl: RTL and testbench

- Sequences a seconds countdown driven by an internal prescaler.
- The prescaler is a 1-cycle tick-enable generator, not a derived clock; all logic is on CLK_IN.
- A small FSM controls the run: start, pause/resume, stop.
- Sits between board push-button logic and the display/LED drivers in the demo design, replacing toggled-clock dividers as the timebase for counting logic.

---
 rtl/countdown_timer_ctrl.sv | 111 +++++++++++
 tb/tb_countdown_timer_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl.sv
// Seconds countdown sequencer with a tick-enable prescaler and a start/pause/stop FSM.
// Everything runs on CLK_IN; the prescaler only produces single-cycle enables.
module countdown_timer_ctrl #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int CNT_W      = 8
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             START,
    input  logic             PAUSE,
    input  logic             STOP,
    input  logic [CNT_W-1:0] LOAD_VAL,
    output logic [CNT_W-1:0] REMAIN,
    output logic             TICK_OUT,
    output logic             DONE,
    output logic             BUSY,
    output logic [1:0]       STATE
);

    localparam int DIV = CLOCK_FREQ / TICK_HZ - 1;
    localparam int PW  = (DIV < 1) ? 1 : $clog2(DIV + 1);
    localparam logic [PW-1:0] DIV_P = PW'(DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic [CNT_W-1:0] r_remain;
    logic             r_tick;
    logic             r_done;
    logic             r_busy;

    logic w_terminal;
    logic w_load_ok;
    logic w_last;

    assign w_terminal = (r_presc == DIV_P);
    assign w_load_ok  = (LOAD_VAL != '0);
    assign w_last     = (r_remain == CNT_W'(1));

    // STOP outranks START, which outranks PAUSE; TICK/DONE default low so they never stretch.
    always_ff @(posedge CLK_IN) begin
        r_tick <= 1'b0;
        r_done <= 1'b0;
        if (RST) begin
            r_state  <= IDLE;
            r_presc  <= '0;
            r_remain <= '0;
            r_busy   <= 1'b0;
        end else if (STOP) begin
            r_state  <= IDLE;
            r_presc  <= '0;
            r_remain <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FIN: begin
                    if (START && w_load_ok) begin
                        r_state  <= RUN;
                        r_remain <= LOAD_VAL;
                        r_presc  <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_terminal) begin
                        r_presc <= '0;
                        r_tick  <= 1'b1;
                        if (r_remain != '0) begin
                            r_remain <= r_remain - CNT_W'(1);
                        end
                        // The final tick wins over a coincident PAUSE.
                        if (w_last) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (PAUSE) begin
                            r_state <= PAUSED;
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                        if (PAUSE) begin
                            r_state <= PAUSED;
                        end
                    end
                end
                PAUSED: begin
                    if (PAUSE) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign REMAIN   = r_remain;
    assign TICK_OUT = r_tick;
    assign DONE     = r_done;
    assign BUSY     = r_busy;
    assign STATE    = r_state;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed table-driven bench for countdown_timer_ctrl with a 4-cycle tick period
// (CLOCK_FREQ=4, TICK_HZ=1), plus a hand-modelled full 255-count run.
module tb_countdown_timer_ctrl;

    typedef struct {
        logic       rst;
        logic       start;
        logic       pause;
        logic       stop;
        logic [7:0] load;
        logic [7:0] expRemain;
        logic       expTick;
        logic       expDone;
        logic       expBusy;
        logic [1:0] expState;
    } vec_t;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;

    logic       CLK_IN = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       PAUSE = 1'b0;
    logic       STOP = 1'b0;
    logic [7:0] LOAD_VAL = 8'd0;
    logic [7:0] REMAIN;
    logic       TICK_OUT;
    logic       DONE;
    logic       BUSY;
    logic [1:0] STATE;

    int checks = 0;
    int errors = 0;
    int vecIdx = 0;
    vec_t vecs[$];

    countdown_timer_ctrl #(
        .CLOCK_FREQ(4),
        .TICK_HZ   (1),
        .CNT_W     (8)
    ) dut (
        .CLK_IN  (CLK_IN),
        .RST     (RST),
        .START   (START),
        .PAUSE   (PAUSE),
        .STOP    (STOP),
        .LOAD_VAL(LOAD_VAL),
        .REMAIN  (REMAIN),
        .TICK_OUT(TICK_OUT),
        .DONE    (DONE),
        .BUSY    (BUSY),
        .STATE   (STATE)
    );

    always #5 CLK_IN = ~CLK_IN;

    // One table row: inputs held for one edge, then the outputs expected after that edge.
    task automatic addVec(input logic rst, input logic start, input logic pause, input logic stop,
                          input logic [7:0] load, input logic [7:0] rem, input logic tick,
                          input logic done, input logic busy, input logic [1:0] st);
        vec_t v;
        v.rst = rst; v.start = start; v.pause = pause; v.stop = stop; v.load = load;
        v.expRemain = rem; v.expTick = tick; v.expDone = done; v.expBusy = busy; v.expState = st;
        vecs.push_back(v);
    endtask

    task automatic addIdle(input int n, input logic [7:0] rem, input logic busy, input logic [1:0] st);
        for (int i = 0; i < n; i++) addVec(0, 0, 0, 0, 8'd0, rem, 0, 0, busy, st);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checks++;
        if (REMAIN !== v.expRemain) begin
            errors++;
            $display("[TB] FAIL step%0d remain: got %0d want %0d", idx, REMAIN, v.expRemain);
        end
        checks++;
        if (TICK_OUT !== v.expTick) begin
            errors++;
            $display("[TB] FAIL step%0d tick: got %b want %b", idx, TICK_OUT, v.expTick);
        end
        checks++;
        if (DONE !== v.expDone) begin
            errors++;
            $display("[TB] FAIL step%0d done: got %b want %b", idx, DONE, v.expDone);
        end
        checks++;
        if (BUSY !== v.expBusy) begin
            errors++;
            $display("[TB] FAIL step%0d busy: got %b want %b", idx, BUSY, v.expBusy);
        end
        checks++;
        if (STATE !== v.expState) begin
            errors++;
            $display("[TB] FAIL step%0d state: got %0d want %0d", idx, STATE, v.expState);
        end
    endtask

    // Inputs change 1 time unit after an edge and outputs are sampled 1 unit after the next.
    task automatic applyStimulus(input vec_t v);
        RST = v.rst; START = v.start; PAUSE = v.pause; STOP = v.stop; LOAD_VAL = v.load;
        @(posedge CLK_IN);
        #1;
        RST = 0; START = 0; PAUSE = 0; STOP = 0; LOAD_VAL = 8'd0;
        checkOutput(v, vecIdx);
        vecIdx++;
    endtask

    initial begin
        vec_t v;
        int tickCount;
        int doneCount;

        // Reset, then illegal requests in IDLE.
        addVec(1, 0, 0, 0, 8'd0, 8'd0, 0, 0, 0, S_IDLE);
        addVec(1, 1, 0, 0, 8'd7, 8'd0, 0, 0, 0, S_IDLE);
        addVec(0, 1, 0, 1, 8'd3, 8'd0, 0, 0, 0, S_IDLE);
        addVec(0, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0, S_IDLE);
        addVec(0, 0, 1, 0, 8'd0, 8'd0, 0, 0, 0, S_IDLE);

        // Basic run from 3: ticks after e0+4, +8, +12, DONE on the third.
        addVec(0, 1, 0, 0, 8'd3, 8'd3, 0, 0, 1, S_RUN);
        addIdle(3, 8'd3, 1, S_RUN);
        addVec(0, 0, 0, 0, 8'd0, 8'd2, 1, 0, 1, S_RUN);
        addIdle(3, 8'd2, 1, S_RUN);
        addVec(0, 0, 0, 0, 8'd0, 8'd1, 1, 0, 1, S_RUN);
        addIdle(3, 8'd1, 1, S_RUN);
        addVec(0, 0, 0, 0, 8'd0, 8'd0, 1, 1, 0, S_FIN);
        addIdle(1, 8'd0, 0, S_FIN);
        addVec(0, 0, 1, 0, 8'd0, 8'd0, 0, 0, 0, S_FIN);
        addVec(0, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0, S_FIN);
        addVec(0, 0, 0, 1, 8'd0, 8'd0, 0, 0, 0, S_IDLE);

        // Pause two edges after START, hold 10, resume: tick 2 edges later, DONE 4 after that.
        addVec(0, 1, 0, 0, 8'd2, 8'd2, 0, 0, 1, S_RUN);
        addIdle(1, 8'd2, 1, S_RUN);
        addVec(0, 0, 1, 0, 8'd0, 8'd2, 0, 0, 1, S_PAUSED);
        addIdle(10, 8'd2, 1, S_PAUSED);
        addVec(0, 0, 1, 0, 8'd0, 8'd2, 0, 0, 1, S_RUN);
        addIdle(1, 8'd2, 1, S_RUN);
        addVec(0, 0, 0, 0, 8'd0, 8'd1, 1, 0, 1, S_RUN);
        addIdle(3, 8'd1, 1, S_RUN);
        addVec(0, 0, 0, 0, 8'd0, 8'd0, 1, 1, 0, S_FIN);
        addVec(0, 0, 0, 1, 8'd0, 8'd0, 0, 0, 0, S_IDLE);

        // STOP on the terminal prescaler cycle of the second period suppresses the tick.
        addVec(0, 1, 0, 0, 8'd5, 8'd5, 0, 0, 1, S_RUN);
        addIdle(3, 8'd5, 1, S_RUN);
        addVec(0, 0, 0, 0, 8'd0, 8'd4, 1, 0, 1, S_RUN);
        addIdle(3, 8'd4, 1, S_RUN);
        addVec(0, 0, 0, 1, 8'd0, 8'd0, 0, 0, 0, S_IDLE);
        addIdle(6, 8'd0, 0, S_IDLE);

        // START during RUN ignored; PAUSE on the final terminal cycle lands in FIN.
        addVec(0, 1, 0, 0, 8'd3, 8'd3, 0, 0, 1, S_RUN);
        addVec(0, 1, 0, 0, 8'd9, 8'd3, 0, 0, 1, S_RUN);
        addIdle(2, 8'd3, 1, S_RUN);
        addVec(0, 0, 0, 0, 8'd0, 8'd2, 1, 0, 1, S_RUN);
        addIdle(3, 8'd2, 1, S_RUN);
        addVec(0, 0, 0, 0, 8'd0, 8'd1, 1, 0, 1, S_RUN);
        addIdle(3, 8'd1, 1, S_RUN);
        addVec(0, 0, 1, 0, 8'd0, 8'd0, 1, 1, 0, S_FIN);
        addIdle(1, 8'd0, 0, S_FIN);

        // PAUSE on a non-final terminal cycle: tick first, then PAUSED; STOP beats START+PAUSE.
        addVec(0, 1, 0, 0, 8'd3, 8'd3, 0, 0, 1, S_RUN);
        addIdle(3, 8'd3, 1, S_RUN);
        addVec(0, 0, 1, 0, 8'd0, 8'd2, 1, 0, 1, S_PAUSED);
        addIdle(2, 8'd2, 1, S_PAUSED);
        addVec(0, 1, 1, 1, 8'd6, 8'd0, 0, 0, 0, S_IDLE);

        // Reset while PAUSED at 4, then a count of 1 finishes 4 edges after START.
        addVec(0, 1, 0, 0, 8'd5, 8'd5, 0, 0, 1, S_RUN);
        addIdle(3, 8'd5, 1, S_RUN);
        addVec(0, 0, 0, 0, 8'd0, 8'd4, 1, 0, 1, S_RUN);
        addVec(0, 0, 1, 0, 8'd0, 8'd4, 0, 0, 1, S_PAUSED);
        addIdle(2, 8'd4, 1, S_PAUSED);
        addVec(1, 0, 0, 0, 8'd0, 8'd0, 0, 0, 0, S_IDLE);
        addVec(0, 1, 0, 0, 8'd1, 8'd1, 0, 0, 1, S_RUN);
        addIdle(3, 8'd1, 1, S_RUN);
        addVec(0, 0, 0, 0, 8'd0, 8'd0, 1, 1, 0, S_FIN);
        addIdle(1, 8'd0, 0, S_FIN);

        @(posedge CLK_IN);
        #1;
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Restart from FIN with 255 and run it out against a period-4 model.
        v.rst = 0; v.start = 1; v.pause = 0; v.stop = 0; v.load = 8'd255;
        v.expRemain = 8'd255; v.expTick = 0; v.expDone = 0; v.expBusy = 1; v.expState = S_RUN;
        applyStimulus(v);
        tickCount = 0;
        doneCount = 0;
        for (int k = 1; k <= 1020; k++) begin
            v.start = 0; v.load = 8'd0;
            v.expTick   = (k % 4 == 0);
            v.expRemain = 8'(255 - k / 4);
            v.expDone   = (k == 1020);
            v.expBusy   = (k < 1020);
            v.expState  = (k < 1020) ? S_RUN : S_FIN;
            applyStimulus(v);
            if (TICK_OUT === 1'b1) tickCount++;
            if (DONE === 1'b1) doneCount++;
        end
        checks++;
        if (tickCount != 255) begin
            errors++;
            $display("[TB] FAIL tickCount255: got %0d want 255", tickCount);
        end
        checks++;
        if (doneCount != 1) begin
            errors++;
            $display("[TB] FAIL doneCount255: got %0d want 1", doneCount);
        end
        v.expTick = 0; v.expDone = 0; v.expBusy = 0; v.expState = S_FIN; v.expRemain = 8'd0;
        applyStimulus(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
